// File: rtl/mips_muldiv_unit_if.sv
// Request/response bundle between the core and the HI/LO multiply/divide unit.
// The core drives the master side and the unit implements the slave side.
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, rs, rt, flush, input busy, done, hi, lo);
    modport slave  (input start, op, rs, rt, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit that owns HI/LO (shift-add multiply, restoring divide).
// Optional macro MULDIV_EARLY_EXIT_EN ends a multiply once no multiplier bits remain.
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    mips_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    localparam logic [2:0]       OP_MULT  = 3'b000;
    localparam logic [2:0]       OP_MULTU = 3'b001;
    localparam logic [2:0]       OP_DIV   = 3'b010;
    localparam logic [2:0]       OP_DIVU  = 3'b011;
    localparam logic [2:0]       OP_MTHI  = 3'b100;
    localparam logic [2:0]       OP_MTLO  = 3'b101;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             div_q, div_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // a_q: multiplicand or divisor magnitude; {acc_q,b_q}: product shift pair or remainder/quotient.
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] prod_mag_s;
    logic [2*WIDTH-1:0] prod_res_s;
    logic               sgn_s;
    logic               mul_last_s;

    assign sgn_s       = ~bus.op[0];
    assign mul_sum_s   = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {acc_q, b_q[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, a_q};
    // cnt_q holds the shifts still owed when a multiply ends early; zero otherwise.
    assign prod_mag_s  = {acc_q, b_q} >> cnt_q;
    assign prod_res_s  = neg_q ? ((~prod_mag_s) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_mag_s;

`ifdef MULDIV_EARLY_EXIT_EN
    logic [WIDTH-1:0] rem_mask_s;
    assign rem_mask_s = ~(W_ONES << (cnt_q - CNT_ONE));
    assign mul_last_s = (cnt_q == CNT_ONE) || (((b_q >> 1) & rem_mask_s) == W_ZERO);
`else
    assign mul_last_s = (cnt_q == CNT_ONE);
`endif

    // Next-state and datapath computation for the sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        div_d   = div_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush) begin
                    busy_d = 1'b0;
                end else if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = mag_w(bus.rs, sgn_s);
                            b_d     = mag_w(bus.rt, sgn_s);
                            acc_d   = W_ZERO;
                            neg_d   = sgn_s & (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
                            rneg_d  = 1'b0;
                            dz_d    = 1'b0;
                            div_d   = 1'b0;
                            cnt_d   = CNT_FULL;
                            busy_d  = 1'b1;
                            state_d = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            div_d  = 1'b1;
                            busy_d = 1'b1;
                            if (bus.rt == W_ZERO) begin
                                acc_d   = bus.rs;
                                b_d     = W_ONES;
                                dz_d    = 1'b1;
                                neg_d   = 1'b0;
                                rneg_d  = 1'b0;
                                cnt_d   = CNT_ZERO;
                                state_d = ST_FIX;
                            end else begin
                                a_d     = mag_w(bus.rt, sgn_s);
                                b_d     = mag_w(bus.rs, sgn_s);
                                acc_d   = W_ZERO;
                                neg_d   = sgn_s & (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
                                rneg_d  = sgn_s & bus.rs[WIDTH-1];
                                dz_d    = 1'b0;
                                cnt_d   = CNT_FULL;
                                state_d = ST_DIV;
                            end
                        end
                        OP_MTHI: hi_d = bus.rs;
                        OP_MTLO: lo_d = bus.rs;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_MUL: begin
                if (bus.flush) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    {acc_d, b_d} = {mul_sum_s, b_q[WIDTH-1:1]};
                    cnt_d        = cnt_q - CNT_ONE;
                    state_d      = mul_last_s ? ST_FIX : ST_MUL;
                end
            end
            ST_DIV: begin
                if (bus.flush) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    // Keep the trial subtraction only when it did not borrow.
                    if (!div_diff_s[WIDTH]) begin
                        acc_d = div_diff_s[WIDTH-1:0];
                        b_d   = {b_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift_s[WIDTH-1:0];
                        b_d   = {b_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = (cnt_q == CNT_ONE) ? ST_FIX : ST_DIV;
                end
            end
            ST_FIX: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (bus.flush) begin
                    done_d = 1'b0;
                end else if (!div_q) begin
                    hi_d   = prod_res_s[2*WIDTH-1:WIDTH];
                    lo_d   = prod_res_s[WIDTH-1:0];
                    done_d = 1'b1;
                end else if (dz_q) begin
                    hi_d   = acc_q;
                    lo_d   = b_q;
                    done_d = 1'b1;
                end else begin
                    hi_d   = rneg_q ? neg_w(acc_q) : acc_q;
                    lo_d   = neg_q ? neg_w(b_q) : b_q;
                    done_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers: async clear, frozen whenever clk_enable is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            a_q     <= W_ZERO;
            b_q     <= W_ZERO;
            acc_q   <= W_ZERO;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= W_ZERO;
            lo_q    <= W_ZERO;
        end else if (clk_enable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            div_q   <= div_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit (WIDTH=32), one task per scenario.
module tb_mips_muldiv_unit;
    localparam int W = 32;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic clk = 1'b0;
    logic reset;
    logic clk_enable;
    int   checks = 0;
    int   errors = 0;

    mips_muldiv_unit_if #(.WIDTH(W)) bus ();
    mips_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1; bus.op = o; bus.rs = a; bus.rt = b;
        tick();
        bus.start = 1'b0;
    endtask

    // n = edges after the start edge until done is seen (-1 if never); busy_cnt = busy-high samples.
    task automatic wait_done(input int max_edges, output int n, output int busy_cnt);
        n = -1;
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        for (int i = 1; i <= max_edges; i++) begin
            tick();
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %h want 0", bus.done); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_multu_max();
        int n, bc;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(60, n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", n); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL multu_busy_in_done got %h want 0", bus.busy); end
        checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
        checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %h want 0", bus.done); end
    endtask

    task automatic test_div_signed();
        int n, bc;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(60, n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", n); end
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_quot got %h want fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_rem got %h want ffffffff", bus.hi); end
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(60, n, bc);
        checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_quot got %h want 0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_rem got %h want 00000002", bus.hi); end
    endtask

    task automatic test_div_zero();
        int n, bc;
        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done(60, n, bc);
        // start edge moves to FIX, the very next edge writes: done seen 1 edge after start.
        checks++; if (n !== 1) begin errors++; $display("FAIL divu0_latency got %0d want 1", n); end
        checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got %h want ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'd100) begin errors++; $display("FAIL divu0_hi got %h want 00000064", bus.hi); end
        issue(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        wait_done(60, n, bc);
        checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h want ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div0_hi got %h want fffffffb", bus.hi); end
    endtask

    task automatic test_div_overflow();
        int n, bc;
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(60, n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL divovf_latency got %0d want 33", n); end
        checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h want 80000000", bus.lo); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL divovf_hi got %h want 0", bus.hi); end
    endtask

    task automatic test_move_flush();
        int seen;
        issue(OP_MTHI, 32'h1234_5678, 32'h0);
        checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", bus.hi); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mthi_handshake got busy=%h done=%h want 0 0", bus.busy, bus.done); end
        issue(OP_MTLO, 32'h0BAD_F00D, 32'h0);
        checks++; if (bus.lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL mtlo_lo got %h want 0badf00d", bus.lo); end
        issue(OP_MULTU, 32'd3, 32'd5);
        for (int i = 0; i < 4; i++) tick();
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_while_busy got %h want 12345678", bus.hi); end
        for (int i = 0; i < 4; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %h want 0", bus.busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done got %0d done cycles want 0", seen); end
        checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL flush_hi got %h want 12345678", bus.hi); end
        checks++; if (bus.lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL flush_lo got %h want 0badf00d", bus.lo); end
    endtask

    task automatic test_back_to_back();
        int n, bc;
        issue(OP_MULTU, 32'd3, 32'd5);
        wait_done(60, n, bc);
        checks++; if (bus.lo !== 32'd15 || bus.hi !== 32'd0) begin errors++; $display("FAIL b2b_first got %h_%h want 00000000_0000000f", bus.hi, bus.lo); end
        issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%h want 1", bus.busy); end
        wait_done(60, n, bc);
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", n); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", bus.lo); end
    endtask

    task automatic test_reset_mid_div();
        int seen;
        issue(OP_DIVU, 32'd1000, 32'd3);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %h want 0", bus.busy); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_hilo got %h_%h want 0_0", bus.hi, bus.lo); end
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.lo !== 32'h0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_result got %0d cycles want 0", seen); end
    endtask

    task automatic test_stall();
        int n, bc;
        issue(OP_MULTU, 32'h0000_1234, 32'h0000_5678);
        for (int i = 0; i < 10; i++) tick();
        clk_enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %h want 1", bus.busy); end
        clk_enable = 1'b1;
        wait_done(60, n, bc);
        checks++; if (n + 15 !== 38) begin errors++; $display("FAIL stall_latency got %0d want 38", n + 15); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0626_0060) begin errors++; $display("FAIL stall_result got %h_%h want 00000000_06260060", bus.hi, bus.lo); end
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stall_done_frozen got %h want 1", bus.done); end
        clk_enable = 1'b1;
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL stall_done_release got %h want 0", bus.done); end
    endtask

    task automatic test_early_exit();
        int n, bc, exp_n;
`ifdef MULDIV_EARLY_EXIT_EN
        exp_n = 2;
`else
        exp_n = 33;
`endif
        issue(OP_MULTU, 32'd9, 32'd1);
        wait_done(60, n, bc);
        checks++; if (n !== exp_n) begin errors++; $display("FAIL early_latency got %0d want %0d", n, exp_n); end
        checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'd9) begin errors++; $display("FAIL early_result got %h_%h want 00000000_00000009", bus.hi, bus.lo); end
        issue(OP_MULT, 32'h8000_0000, 32'h0000_0002);
        wait_done(60, n, bc);
        checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'h0) begin errors++; $display("FAIL mult_minneg got %h_%h want ffffffff_00000000", bus.hi, bus.lo); end
    endtask

    initial begin
        clk_enable = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'b000; bus.rs = 32'h0; bus.rt = 32'h0;
        test_reset();
        test_multu_max();
        test_div_signed();
        test_div_zero();
        test_div_overflow();
        test_move_flush();
        test_back_to_back();
        test_reset_mid_div();
        test_stall();
        test_early_exit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit owning the MIPS HI/LO registers; successor to the single-cycle HI/LO path in the ALU.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles with a start/busy/done handshake. MTHI and MTLO are single-cycle.
- Sits beside the ALU. The core issues an op on rs/rt contents, stalls on busy for MFHI/MFLO, and reads hi/lo directly.

Parameters:
- WIDTH, 32, operand width and HI/LO register width in bits (even, >=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clk_enable  in  1  when low, all state, counters and outputs hold.
- start  in  1  request strobe, sampled on rising clk.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are no-op.
- rs  in  WIDTH  operand A (dividend/multiplicand); MTHI/MTLO source.
- rt  in  WIDTH  operand B (divisor/multiplier).
- flush  in  1  cancel in-flight op (exception/squash).
- busy  out  1  op in flight; HI/LO not yet valid.
- done  out  1  one-cycle pulse after HI/LO updated by MULT/MULTU/DIV/DIVU.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- Clock gating: all transitions below require clk_enable=1. When clk_enable=0, everything freezes, including a pending done pulse.
- States:
  - IDLE: start=1 with a mul/div op latches operands, sets counter=WIDTH and busy=1, and moves to MUL or DIV.
  - MUL/DIV: one result bit per edge, counter decrements; at counter==1 the next edge moves to FIX.
  - FIX: applies sign correction, writes hi/lo, busy=0, done=1 for the following cycle, then returns to IDLE.
- Latency: start edge to hi/lo-write edge is WIDTH+1 edges (33 for WIDTH=32). done is high in the cycle after the write; busy is low in that same cycle.
- start while busy=1 is ignored. No queueing and no error flag. start in the done cycle is accepted (back-to-back).
- MTHI/MTLO: when not busy, hi/lo is written on the start edge. No busy, no done. Ignored while busy.
- MULT/MULTU: {hi,lo} = rs*rt as a 2*WIDTH-bit product, signed or unsigned per op.
- Signed ops: operate on magnitudes, then negate in FIX.
  - Product sign = rs[MSB]^rt[MSB].
  - Quotient sign = rs[MSB]^rt[MSB]; remainder sign = sign of dividend.
- DIV/DIVU: restoring division; lo=quotient, hi=remainder.
- Divide by zero (rt==0): skips iteration, IDLE->FIX (result on the 2nd edge). lo=all ones, hi=rs, for both signed and unsigned.
- Signed overflow (rs=most-negative, rt=-1): lo=most-negative, hi=0; full latency.
- flush=1 (any state, priority over start): the next edge returns to IDLE, busy=0, no done. hi/lo keep their pre-op values.
- Reset mid-op: asynchronous clear as above. A partial result is never written.
- hi/lo change only on the FIX edge, an MTHI/MTLO edge, or reset.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined: in MUL, if the remaining unshifted multiplier bits are all zero, the next edge goes to FIX. Latency becomes (index of highest set bit of |rt|)+2 edges; rt==0 gives 2 edges. DIV is unaffected.
- Undefined: fixed WIDTH+1 edges for all mul/div ops. Results are identical either way.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001; done high exactly 1 cycle; busy high 33 cycles.
- MULT rs=0xFFFFFFFE(-2) rt=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. DIV rs=-7 rt=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
- DIVU rs=100 rt=0 -> result on 2nd edge: lo=0xFFFFFFFF, hi=100. DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0x12345678 then MULTU 3*5; flush at cycle 10 -> hi=0x12345678 retained, lo unchanged, no done; start during busy ignored.
- Async reset asserted mid-DIV, and clk_enable low for 5 cycles mid-MUL -> reset clears all outputs immediately; stall extends latency to 38 edges with a correct result.
- With MULDIV_EARLY_EXIT_EN: MULTU rs=9 rt=1 -> hi=0, lo=9 after 2 edges. Without it: the same result after 33 edges.
